// File: rtl/aipp_pkg.sv
// Shared types and defaults for the AIPP pre-emptive VID boost sequencer.
package aipp_pkg;

   localparam int VID_W_DEF    = 8;
   localparam int VID_STEP_DEF = 1;
   localparam int HOLD_W_DEF   = 16;
   localparam int CNT_W_DEF    = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LEAD      = 3'd1,
      RAMP_UP   = 3'd2,
      HOLD      = 3'd3,
      RAMP_DOWN = 3'd4,
      COOLDOWN  = 3'd5
   } state_t;

   // Increment v, sticking at the all-ones value of a w-bit counter.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/aipp_vid_stepper.sv
// VID step generator: owns the current setpoint, clamped step arithmetic and
// the valid/ready output register towards the VRM interface.
module aipp_vid_stepper
   import aipp_pkg::*;
#(
   parameter int VID_W    = VID_W_DEF,
   parameter int VID_STEP = VID_STEP_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_i,
   input  logic [VID_W-1:0] init_vid_i,
   input  logic             up_i,
   input  logic             down_i,
   input  logic [VID_W-1:0] up_cap_i,
   input  logic [VID_W-1:0] down_cap_i,
   input  logic             vid_ready_i,
   output logic [VID_W-1:0] vid_out_o,
   output logic             vid_valid_o,
   output logic             accepted_o,
   output logic             done_o
);

   localparam int XW = VID_W + 1;

   logic [VID_W-1:0] cur_vid_q, cur_vid_d, vid_q, vid_d;
   logic [VID_W-1:0] base, up_val, down_val;
   logic [VID_W:0]   base_x, up_sum, down_lim;
   logic             valid_q, valid_d, dir_up_q, dir_up_d;
   logic             fire, issue;

   // Handshake: a transfer completes on a cycle with vid_valid_o & vid_ready_i.
   // Once valid is raised, vid_out_o is frozen until that cycle; ready alone
   // (valid low) has no effect.
   assign fire        = valid_q & vid_ready_i;
   assign accepted_o  = fire;
   assign done_o      = fire & (vid_q == (dir_up_q ? up_cap_i : down_cap_i));
   assign vid_out_o   = vid_q;
   assign vid_valid_o = valid_q;

   always_comb begin
      // The step after an accepted transfer builds on the value just accepted.
      base     = fire ? vid_q : cur_vid_q;
      base_x   = {1'b0, base};
      up_sum   = base_x + XW'(VID_STEP);
      up_val   = (up_sum > {1'b0, up_cap_i}) ? up_cap_i : up_sum[VID_W-1:0];
      down_lim = {1'b0, down_cap_i} + XW'(VID_STEP);
      down_val = (base_x < down_lim) ? down_cap_i : base - VID_W'(VID_STEP);
      issue    = (up_i | down_i) & (~valid_q | fire);

      cur_vid_d = cur_vid_q;
      vid_d     = vid_q;
      valid_d   = valid_q;
      dir_up_d  = dir_up_q;
      if (fire) begin
         cur_vid_d = vid_q;
         valid_d   = 1'b0;
      end
      if (init_i) begin
         cur_vid_d = init_vid_i;
      end
      if (issue) begin
         vid_d    = up_i ? up_val : down_val;
         valid_d  = 1'b1;
         dir_up_d = up_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_vid_q <= '0;
         vid_q     <= '0;
         valid_q   <= 1'b0;
         dir_up_q  <= 1'b0;
      end else begin
         cur_vid_q <= cur_vid_d;
         vid_q     <= vid_d;
         valid_q   <= valid_d;
         dir_up_q  <= dir_up_d;
      end
   end

endmodule

// File: rtl/aipp_boost_sequencer.sv
// Pre-emptive VRM boost sequencer: on a trigger rising edge waits a lead time,
// ramps VID to the boost level, holds, ramps back to nominal and cools down.
module aipp_boost_sequencer
   import aipp_pkg::*;
#(
   parameter int VID_W    = VID_W_DEF,
   parameter int VID_STEP = VID_STEP_DEF,
   parameter int HOLD_W   = HOLD_W_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trigger_i,
   input  logic [VID_W-1:0]  nominal_vid,
   input  logic [VID_W-1:0]  boost_vid,
   input  logic [CNT_W-1:0]  lead_cycles,
   input  logic [HOLD_W-1:0] hold_cycles,
   input  logic [CNT_W-1:0]  cooldown_cycles,
   output logic [VID_W-1:0]  vid_out,
   output logic              vid_valid,
   input  logic              vid_ready,
   output logic              boost_active,
   output logic              busy,
   output logic              cfg_err,
   output logic [CNT_W-1:0]  retrig_count,
   output logic [CNT_W-1:0]  drop_count,
   output logic [2:0]        state_o
);

   state_t            state_q, state_d;
   logic              trig_q, trig_edge;
   logic [CNT_W-1:0]  lead_q, lead_d, cool_q, cool_d, cool_cfg_q, cool_cfg_d;
   logic [HOLD_W-1:0] hold_q, hold_d, hold_cfg_q, hold_cfg_d;
   logic [VID_W-1:0]  nom_q, nom_d, bst_q, bst_d;
   logic [CNT_W-1:0]  retrig_q, retrig_d, drop_q, drop_d;
   logic              rev_q, rev_d, cfg_err_q, cfg_err_d;
   logic              busy_q, busy_d, act_q, act_d;
   logic              st_init, st_up, st_down, st_acc, st_done;

   assign trig_edge    = trigger_i & ~trig_q;
   assign boost_active = act_q;
   assign busy         = busy_q;
   assign cfg_err      = cfg_err_q;
   assign retrig_count = retrig_q;
   assign drop_count   = drop_q;
   assign state_o      = state_q;

   aipp_vid_stepper #(.VID_W(VID_W), .VID_STEP(VID_STEP)) u_stepper (
      .clk         (clk),
      .rst         (rst),
      .init_i      (st_init),
      .init_vid_i  (nominal_vid),
      .up_i        (st_up),
      .down_i      (st_down),
      .up_cap_i    (bst_q),
      .down_cap_i  (nom_q),
      .vid_ready_i (vid_ready),
      .vid_out_o   (vid_out),
      .vid_valid_o (vid_valid),
      .accepted_o  (st_acc),
      .done_o      (st_done)
   );

   always_comb begin
      state_d    = state_q;
      lead_d     = lead_q;
      hold_d     = hold_q;
      cool_d     = cool_q;
      nom_d      = nom_q;
      bst_d      = bst_q;
      hold_cfg_d = hold_cfg_q;
      cool_cfg_d = cool_cfg_q;
      retrig_d   = retrig_q;
      drop_d     = drop_q;
      rev_d      = rev_q;
      cfg_err_d  = 1'b0;
      st_init    = 1'b0;
      st_up      = 1'b0;
      st_down    = 1'b0;

      case (state_q)
         IDLE: begin
            if (trig_edge) begin
               if (boost_vid <= nominal_vid) begin
                  cfg_err_d = 1'b1;
               end else begin
                  state_d    = LEAD;
                  lead_d     = lead_cycles;
                  nom_d      = nominal_vid;
                  bst_d      = boost_vid;
                  hold_cfg_d = hold_cycles;
                  cool_cfg_d = cooldown_cycles;
                  st_init    = 1'b1;
               end
            end
         end
         LEAD: begin
            if (trig_edge) drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
            if (lead_q == '0) begin
               state_d = RAMP_UP;
               st_up   = 1'b1;
            end else begin
               lead_d = lead_q - CNT_W'(1);
            end
         end
         RAMP_UP: begin
            if (trig_edge) drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
            if (st_done) begin
               state_d = HOLD;
               hold_d  = hold_cfg_q;
            end else if (st_acc) begin
               st_up = 1'b1;
            end
         end
         HOLD: begin
            if (trig_edge) begin
               hold_d   = hold_cycles;
               retrig_d = CNT_W'(sat_inc(32'(retrig_q), CNT_W));
            end else if (hold_q == '0) begin
               state_d = RAMP_DOWN;
               st_down = 1'b1;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         RAMP_DOWN: begin
            // Reaching nominal beats any reversal request, which is then counted as dropped.
            if (st_done) begin
               state_d = COOLDOWN;
               cool_d  = cool_cfg_q;
               rev_d   = 1'b0;
               if (trig_edge | rev_q) drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
            end else if (st_acc | ~vid_valid) begin
               if (trig_edge | rev_q) begin
                  state_d = RAMP_UP;
                  st_up   = 1'b1;
                  rev_d   = 1'b0;
               end else begin
                  st_down = 1'b1;
               end
            end else if (trig_edge) begin
               rev_d = 1'b1;
            end
         end
         COOLDOWN: begin
            if (trig_edge) drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
            if (cool_q <= CNT_W'(1)) begin
               state_d = IDLE;
            end else begin
               cool_d = cool_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      act_d  = (state_d == RAMP_UP) || (state_d == HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         trig_q     <= 1'b0;
         lead_q     <= '0;
         hold_q     <= '0;
         cool_q     <= '0;
         nom_q      <= '0;
         bst_q      <= '0;
         hold_cfg_q <= '0;
         cool_cfg_q <= '0;
         retrig_q   <= '0;
         drop_q     <= '0;
         rev_q      <= 1'b0;
         cfg_err_q  <= 1'b0;
         busy_q     <= 1'b0;
         act_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         trig_q     <= trigger_i;
         lead_q     <= lead_d;
         hold_q     <= hold_d;
         cool_q     <= cool_d;
         nom_q      <= nom_d;
         bst_q      <= bst_d;
         hold_cfg_q <= hold_cfg_d;
         cool_cfg_q <= cool_cfg_d;
         retrig_q   <= retrig_d;
         drop_q     <= drop_d;
         rev_q      <= rev_d;
         cfg_err_q  <= cfg_err_d;
         busy_q     <= busy_d;
         act_q      <= act_d;
      end
   end

endmodule

// File: tb/tb_aipp_boost_sequencer.sv
// Self-checking bench for aipp_boost_sequencer: scenario tasks plus a VID
// transfer scoreboard fed with the expected setpoint sequence.
`timescale 1ns/1ps
module tb_aipp_boost_sequencer;

   localparam int VID_W  = 8;
   localparam int HOLD_W = 16;
   localparam int CNT_W  = 8;
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_COOLDOWN = 3'd5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              trigger_i = 1'b0;
   logic              trig3 = 1'b0;
   logic [VID_W-1:0]  nominal_vid = '0;
   logic [VID_W-1:0]  boost_vid = '0;
   logic [CNT_W-1:0]  lead_cycles = '0;
   logic [HOLD_W-1:0] hold_cycles = '0;
   logic [CNT_W-1:0]  cooldown_cycles = '0;
   logic              vid_ready = 1'b0;
   logic              ready3 = 1'b0;

   logic [VID_W-1:0]  vid_out, vid_out3;
   logic              vid_valid, boost_active, busy, cfg_err;
   logic              vid_valid3, boost_active3, busy3, cfg_err3;
   logic [CNT_W-1:0]  retrig_count, drop_count, retrig_count3, drop_count3;
   logic [2:0]        state_o, state3;

   int n_cmp = 0;
   int n_err = 0;
   logic [VID_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   aipp_boost_sequencer dut (
      .clk(clk), .rst(rst), .trigger_i(trigger_i),
      .nominal_vid(nominal_vid), .boost_vid(boost_vid),
      .lead_cycles(lead_cycles), .hold_cycles(hold_cycles), .cooldown_cycles(cooldown_cycles),
      .vid_out(vid_out), .vid_valid(vid_valid), .vid_ready(vid_ready),
      .boost_active(boost_active), .busy(busy), .cfg_err(cfg_err),
      .retrig_count(retrig_count), .drop_count(drop_count), .state_o(state_o)
   );

   aipp_boost_sequencer #(.VID_STEP(3)) dut3 (
      .clk(clk), .rst(rst), .trigger_i(trig3),
      .nominal_vid(nominal_vid), .boost_vid(boost_vid),
      .lead_cycles(lead_cycles), .hold_cycles(hold_cycles), .cooldown_cycles(cooldown_cycles),
      .vid_out(vid_out3), .vid_valid(vid_valid3), .vid_ready(ready3),
      .boost_active(boost_active3), .busy(busy3), .cfg_err(cfg_err3),
      .retrig_count(retrig_count3), .drop_count(drop_count3), .state_o(state3)
   );

   // Scoreboard: every accepted transfer of the main instance is popped and compared.
   always @(negedge clk) begin
      logic [VID_W-1:0] ev;
      if (!rst && vid_valid && vid_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_extra: got vid_out=%h accepted, required no transfer", vid_out);
         end else begin
            ev = exp_q.pop_front();
            if (vid_out !== ev) begin
               n_err++;
               $display("FAIL sb_vid: got vid_out=%h, required %h", vid_out, ev);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      trigger_i = 1'b0;
      trig3 = 1'b0;
      vid_ready = 1'b0;
      ready3 = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic set_cfg(input logic [7:0] nom, input logic [7:0] bst, input logic [7:0] lead,
                          input logic [15:0] hold, input logic [7:0] cool);
      nominal_vid = nom;
      boost_vid = bst;
      lead_cycles = lead;
      hold_cycles = hold;
      cooldown_cycles = cool;
   endtask

   task automatic push_ramp(input logic [7:0] from_v, input logic [7:0] to_v);
      logic [7:0] v;
      v = from_v;
      while (v != to_v) begin
         v = (to_v > v) ? v + 8'd1 : v - 8'd1;
         exp_q.push_back(v);
      end
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (busy && k < 300) begin
         tick();
         k++;
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s_idle_timeout: busy=%b, required 0", tag, busy);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_sb_left: %0d transfers outstanding, required 0", tag, exp_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({vid_out, vid_valid, boost_active, busy, cfg_err} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got vid=%h v=%b a=%b b=%b e=%b, required all 0",
                  vid_out, vid_valid, boost_active, busy, cfg_err);
      end
      n_cmp++;
      if ({retrig_count, drop_count, state_o} !== '0) begin
         n_err++;
         $display("FAIL reset_counters: got retrig=%0d drop=%0d state=%0d, required 0/0/0",
                  retrig_count, drop_count, state_o);
      end
   endtask

   task automatic test_nominal();
      logic ev, ea, eb;
      do_reset();
      set_cfg(8'h40, 8'h44, 8'd3, 16'd5, 8'd4);
      vid_ready = 1'b1;
      push_ramp(8'h40, 8'h44);
      push_ramp(8'h44, 8'h40);
      trigger_i = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         tick();
         trigger_i = 1'b0;
         ev = (c >= 5 && c <= 8) || (c >= 15 && c <= 18);
         ea = (c >= 5 && c <= 14);
         eb = (c <= 22);
         n_cmp++;
         if ({vid_valid, boost_active, busy} !== {ev, ea, eb}) begin
            n_err++;
            $display("FAIL nominal_flags c=%0d: got valid/active/busy=%b%b%b, required %b%b%b",
                     c, vid_valid, boost_active, busy, ev, ea, eb);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL nominal_sb_left: %0d transfers outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic prev_stall, fin;
      logic [7:0] prev_v;
      int acc;
      do_reset();
      set_cfg(8'h40, 8'h44, 8'd3, 16'd5, 8'd4);
      push_ramp(8'h40, 8'h44);
      push_ramp(8'h44, 8'h40);
      acc = 0;
      prev_stall = 1'b0;
      prev_v = '0;
      fin = 1'b0;
      trigger_i = 1'b1;
      for (int c = 0; c < 200 && !fin; c++) begin
         tick();
         trigger_i = 1'b0;
         if (prev_stall) begin
            n_cmp++;
            if (!vid_valid || vid_out !== prev_v) begin
               n_err++;
               $display("FAIL bp_stable: got valid=%b vid=%h, required valid=1 vid=%h",
                        vid_valid, vid_out, prev_v);
            end
         end
         vid_ready = ~vid_ready;
         prev_stall = vid_valid && !vid_ready;
         prev_v = vid_out;
         if (vid_valid && vid_ready) acc++;
         fin = !busy;
      end
      n_cmp++;
      if (acc != 8) begin
         n_err++;
         $display("FAIL bp_count: got %0d transfers, required 8", acc);
      end
      n_cmp++;
      if (busy !== 1'b0 || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL bp_end: got busy=%b outstanding=%0d, required busy=0 outstanding=0",
                  busy, exp_q.size());
      end
   endtask

   task automatic test_retrigger();
      int k;
      do_reset();
      set_cfg(8'h40, 8'h44, 8'd3, 16'd5, 8'd4);
      vid_ready = 1'b1;
      push_ramp(8'h40, 8'h44);
      push_ramp(8'h44, 8'h40);
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      k = 0;
      while (!(boost_active && !vid_valid) && k < 50) begin
         tick();
         k++;
      end
      n_cmp++;
      if (!(boost_active && !vid_valid)) begin
         n_err++;
         $display("FAIL retrig_hold_reach: active=%b valid=%b, required 1/0", boost_active, vid_valid);
      end
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      tick();
      hold_cycles = 16'd3;
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         if (n > 1) tick();
         n_cmp++;
         if (vid_valid !== (n == 5)) begin
            n_err++;
            $display("FAIL retrig_hold_len n=%0d: got valid=%b, required %b", n, vid_valid, (n == 5));
         end
      end
      n_cmp++;
      if (retrig_count !== 8'd2 || drop_count !== 8'd0) begin
         n_err++;
         $display("FAIL retrig_counts: got retrig=%0d drop=%0d, required 2/0", retrig_count, drop_count);
      end
      wait_idle("retrig");
   endtask

   task automatic test_reversal();
      int k;
      do_reset();
      set_cfg(8'h40, 8'h44, 8'd1, 16'd2, 8'd2);
      vid_ready = 1'b1;
      push_ramp(8'h40, 8'h44);
      push_ramp(8'h44, 8'h42);
      push_ramp(8'h42, 8'h44);
      push_ramp(8'h44, 8'h40);
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      k = 0;
      while (!(vid_valid && !boost_active && vid_out == 8'h42) && k < 60) begin
         tick();
         k++;
      end
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      n_cmp++;
      if (!boost_active || !vid_valid || vid_out !== 8'h43) begin
         n_err++;
         $display("FAIL rev_up: got active=%b valid=%b vid=%h, required 1/1/43",
                  boost_active, vid_valid, vid_out);
      end
      wait_idle("rev");
      n_cmp++;
      if (drop_count !== 8'd0 || retrig_count !== 8'd0) begin
         n_err++;
         $display("FAIL rev_counts: got drop=%0d retrig=%0d, required 0/0", drop_count, retrig_count);
      end
   endtask

   task automatic test_drops();
      int k;
      do_reset();
      set_cfg(8'h40, 8'h42, 8'd3, 16'd1, 8'd4);
      vid_ready = 1'b1;
      push_ramp(8'h40, 8'h42);
      push_ramp(8'h42, 8'h40);
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      tick();
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      k = 0;
      while (state_o != ST_COOLDOWN && k < 60) begin
         tick();
         k++;
      end
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      wait_idle("drops");
      n_cmp++;
      if (drop_count !== 8'd2 || retrig_count !== 8'd0) begin
         n_err++;
         $display("FAIL drop_counts: got drop=%0d retrig=%0d, required 2/0", drop_count, retrig_count);
      end
   endtask

   task automatic test_cfg_err();
      do_reset();
      vid_ready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         set_cfg(8'h40, (t == 0) ? 8'h40 : 8'h3F, 8'd1, 16'd1, 8'd1);
         trigger_i = 1'b1;
         tick();
         trigger_i = 1'b0;
         n_cmp++;
         if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_err_pulse t=%0d: got err=%b busy=%b, required 1/0", t, cfg_err, busy);
         end
         for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if ({cfg_err, busy, vid_valid} !== 3'b000) begin
               n_err++;
               $display("FAIL cfg_err_after t=%0d c=%0d: got err/busy/valid=%b%b%b, required 000",
                        t, c, cfg_err, busy, vid_valid);
            end
         end
      end
   endtask

   task automatic test_reset_mid_ramp();
      int k;
      do_reset();
      set_cfg(8'h40, 8'h44, 8'd2, 16'd2, 8'd2);
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      k = 0;
      while (!vid_valid && k < 20) begin
         tick();
         k++;
      end
      n_cmp++;
      if (vid_valid !== 1'b1 || vid_out !== 8'h41) begin
         n_err++;
         $display("FAIL rst_mid_pre: got valid=%b vid=%h, required 1/41", vid_valid, vid_out);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({vid_out, vid_valid, boost_active, busy, cfg_err, state_o} !== {8'h00, 4'b0000, ST_IDLE}) begin
         n_err++;
         $display("FAIL rst_mid_outputs: got vid=%h v=%b a=%b b=%b e=%b st=%0d, required all 0",
                  vid_out, vid_valid, boost_active, busy, cfg_err, state_o);
      end
      vid_ready = 1'b1;
      push_ramp(8'h40, 8'h44);
      push_ramp(8'h44, 8'h40);
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_restart: got busy=%b, required 1", busy);
      end
      wait_idle("rst_mid");
   endtask

   task automatic test_step3_no_wrap();
      logic [7:0] exp3_q[$];
      logic [7:0] ev;
      logic e_v, e_b;
      do_reset();
      set_cfg(8'hFD, 8'hFF, 8'd0, 16'd0, 8'd0);
      ready3 = 1'b1;
      exp3_q.push_back(8'hFF);
      exp3_q.push_back(8'hFD);
      trig3 = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         trig3 = 1'b0;
         e_v = (c == 2) || (c == 4);
         e_b = (c <= 5);
         n_cmp++;
         if ({vid_valid3, busy3} !== {e_v, e_b}) begin
            n_err++;
            $display("FAIL step3_flags c=%0d: got valid/busy=%b%b, required %b%b",
                     c, vid_valid3, busy3, e_v, e_b);
         end
         if (vid_valid3 && ready3) begin
            n_cmp++;
            if (exp3_q.size() == 0) begin
               n_err++;
               $display("FAIL step3_extra: got vid=%h, required no transfer", vid_out3);
            end else begin
               ev = exp3_q.pop_front();
               if (vid_out3 !== ev) begin
                  n_err++;
                  $display("FAIL step3_vid c=%0d: got vid=%h, required %h", c, vid_out3, ev);
               end
            end
         end
      end
      n_cmp++;
      if (exp3_q.size() != 0) begin
         n_err++;
         $display("FAIL step3_left: %0d transfers outstanding, required 0", exp3_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_retrigger();
      test_reversal();
      test_drops();
      test_cfg_err();
      test_reset_mid_ramp();
      test_step3_no_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aipp_boost_sequencer.md
Name: aipp_boost_sequencer

Overview:
- Downstream of the AIPP header parser: consumes its trigger and runs a pre-emptive voltage boost on the VRM setpoint (VID) link before the heavy job's current step arrives.
- On each trigger rising edge: wait a lead time, ramp VID up to a boost level, hold it, ramp it back to nominal, then enforce a cooldown.
- Each VID step is sent over a valid/ready handshake to the VRM interface block.

Parameters:
- VID_W, 8, width of VID codes.
- VID_STEP, 1, VID increment/decrement per accepted transfer (must be ≥1).
- HOLD_W, 16, width of the hold counter and of hold_cycles.
- CNT_W, 8, width of the lead/cooldown counters and the statistics counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- trigger_i  in  1  level trigger from the parser; the rising edge starts or extends a boost.
- nominal_vid  in  VID_W  idle setpoint.
- boost_vid  in  VID_W  boost setpoint.
- lead_cycles  in  CNT_W  cycles from edge acceptance to the first ramp step.
- hold_cycles  in  HOLD_W  cycles to hold at boost_vid.
- cooldown_cycles  in  CNT_W  lockout after returning to nominal.
- vid_out  out  VID_W  setpoint payload.
- vid_valid  out  1  payload valid.
- vid_ready  in  1  VRM accepts the payload.
- boost_active  out  1  high in RAMP_UP and HOLD.
- busy  out  1  high whenever state != IDLE.
- cfg_err  out  1  one-cycle pulse: trigger rejected because boost_vid <= nominal_vid.
- retrig_count  out  CNT_W  saturating count of hold extensions.
- drop_count  out  CNT_W  saturating count of edges ignored in LEAD, RAMP_UP or COOLDOWN.

Behaviour:
- Edge detect:
  - edge = trigger_i & ~trig_q; trig_q is registered and resets to 0.
- Reset (synchronous, any state, mid-transfer included):
  - state=IDLE.
  - vid_out=0, vid_valid=0, boost_active=0, busy=0, cfg_err=0.
  - All counters = 0.
  - An in-flight transfer is abandoned; no completion is required.
- Config capture:
  - nominal_vid, boost_vid, hold_cycles and cooldown_cycles are sampled into registers on the accepted IDLE edge.
  - Later input changes have no effect until the next sequence starts.
- IDLE:
  - edge with boost_vid <= nominal_vid: cfg_err pulses the next cycle and the block stays IDLE.
  - Valid edge at cycle T: state=LEAD at T+1, lead counter loaded with lead_cycles, cur_vid=nominal_vid.
- LEAD:
  - Counts down one per cycle; at 0 goes to RAMP_UP.
  - lead_cycles=0: RAMP_UP at T+2.
- RAMP_UP:
  - Presents vid_out = min(cur_vid+VID_STEP, boost_cap), computed at VID_W+1 bits so there is no wrap.
  - vid_valid asserts on the first RAMP_UP cycle.
  - On vid_valid & vid_ready: cur_vid is updated.
  - If the accepted value == boost_cap: go to HOLD and load the hold counter.
  - Otherwise: present the next step the following cycle with vid_valid still high (back-to-back steps allowed).
- HOLD:
  - vid_valid=0; counts down.
  - edge: reload hold_cycles from the input and increment retrig_count (saturating).
  - Counter at 0: go to RAMP_DOWN.
  - hold_cycles=0: exactly one HOLD cycle.
- RAMP_DOWN:
  - Mirror of RAMP_UP: vid_out = max(cur_vid-VID_STEP, nom_cap), with no underflow.
  - Accepting nom_cap: go to COOLDOWN.
  - edge while vid_valid=0 or the current transfer is accepted: go to RAMP_UP from the new cur_vid.
  - edge while a transfer is pending: the edge is latched and the reversal happens after acceptance.
- COOLDOWN:
  - Counts cooldown_cycles, then goes to IDLE.
  - edges are ignored and increment drop_count.
- Edges in LEAD or RAMP_UP: ignored and increment drop_count.
- Handshake rules:
  - Once vid_valid=1, vid_out is stable and vid_valid stays high until vid_ready.
  - vid_ready while vid_valid=0 is ignored.
- Edge coincident with the final ramp-down acceptance: COOLDOWN wins and drop_count increments.
- Counters saturate at all-ones and never wrap.

Decomposition:
- aipp_pkg holds:
  - the state enum (IDLE, LEAD, RAMP_UP, HOLD, RAMP_DOWN, COOLDOWN);
  - VID_W, VID_STEP defaults;
  - the saturating-increment function.
- Natural sub-module: aipp_vid_stepper.
  - Owns cur_vid, the saturating step arithmetic and the valid/ready holding register.
  - Its command interface is {up, down, target} plus a done/accepted pulse back to the FSM.

Test Plan:
1. nominal=0x40, boost=0x44, lead=3, hold=5, cooldown=4, vid_ready=1, edge at T:
   - vid_valid high T+5..T+8 with 0x41,0x42,0x43,0x44;
   - HOLD 6 cycles, then 0x43..0x40;
   - COOLDOWN 4 cycles, then busy=0.
2. Same config, vid_ready toggled 1/0 per cycle:
   - vid_out stable while vid_ready=0;
   - exactly 8 transfers accepted in total;
   - the sequence is never skipped.
3. Re-edge twice during HOLD:
   - retrig_count=2;
   - HOLD length = reload-to-expiry measured from the last edge plus 1.
4. Edge during RAMP_DOWN at vid 0x42 with vid_ready=1:
   - ramps back up to 0x43,0x44 and re-enters HOLD;
   - drop_count unchanged.
5. boost=0x40, nominal=0x40, edge:
   - cfg_err pulses 1 cycle;
   - busy stays 0; no vid_valid.
6. rst asserted mid-RAMP_UP with vid_valid=1:
   - next cycle all outputs 0, state IDLE;
   - a new edge restarts cleanly.
   - Also: VID_STEP=3, nominal=0xFD, boost=0xFF: emits 0xFF once with no wrap.
